// File: rtl/fetch_queue_pkg.sv
// Shared constants for the fetch queue: NOP encoding, reset pc and default width.
package fetch_queue_pkg;

    localparam int          XLEN_DEFAULT = 32;
    localparam logic [31:0] NOP          = 32'h0000_0013;   // addi x0, x0, 0
    localparam logic [31:0] PC_RESET     = 32'h0000_0000;

endpackage

// File: rtl/fetch_queue_if.sv
// Handshake bundle between fetch (IF), the fetch queue and decode (ID).
// master = the IF/ID side driving the queue, slave = the queue itself.
interface fetch_queue_if #(
    parameter int XLEN  = fetch_queue_pkg::XLEN_DEFAULT,
    parameter int DEPTH = 4
) ();
    import fetch_queue_pkg::*;

    logic                       i_valid;
    logic [XLEN-1:0]            i_pc;
    logic [XLEN-1:0]            i_instr;
    logic                       o_ready;
    logic                       o_valid;
    logic [XLEN-1:0]            o_pc;
    logic [XLEN-1:0]            o_instr;
    logic                       i_ready;
    logic                       i_flush;
    logic [$clog2(DEPTH):0]     o_count;

    modport master (
        output i_valid, i_pc, i_instr, i_ready, i_flush,
        input  o_ready, o_valid, o_pc, o_instr, o_count
    );

    modport slave (
        input  i_valid, i_pc, i_instr, i_ready, i_flush,
        output o_ready, o_valid, o_pc, o_instr, o_count
    );
endinterface

// File: rtl/fetch_queue_ram.sv
// Entry storage: DEPTH x WIDTH register array, one synchronous write port and
// one asynchronous read port so the head entry is visible without a read cycle.
module fetch_queue_ram #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);
    logic [WIDTH-1:0] mem [DEPTH];

    // Write the addressed entry on an accepted push; contents survive reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/fetch_queue.sv
// Decoupling queue between IF and ID. Circular buffer with wrap-bit pointers,
// flushed on redirect, presenting a NOP when nothing is held.
// Optional feature macro: FETCH_QUEUE_BYPASS_EN (zero-latency pass-through
// of the input when the queue is empty).
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int XLEN  = XLEN_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    fetch_queue_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]        wr_ptr_reg, wr_ptr_next;
    logic [AW:0]        rd_ptr_reg, rd_ptr_next;
    logic               empty, full;
    logic               push, pop, bypass;
    logic [2*XLEN-1:0]  rd_data;

    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]) &&
                   (wr_ptr_reg[AW] != rd_ptr_reg[AW]);

    // o_ready depends on registered state only, so ID never reaches IF
    // combinationally; a full queue refuses a push even while popping.
    assign bus.o_ready = ~full;
    assign bus.o_count = wr_ptr_reg - rd_ptr_reg;

`ifdef FETCH_QUEUE_BYPASS_EN
    assign bypass = empty & bus.i_valid & ~bus.i_flush;
`else
    assign bypass = 1'b0;
`endif

    // An instruction bypassed and consumed in the same cycle is never written.
    assign push = bus.i_valid & ~full & ~bus.i_flush & ~(bypass & bus.i_ready);
    assign pop  = ~empty & bus.i_ready & ~bus.i_flush;

    fetch_queue_ram #(
        .DEPTH (DEPTH),
        .WIDTH (2*XLEN)
    ) u_ram (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr_reg[AW-1:0]),
        .wdata ({bus.i_pc, bus.i_instr}),
        .raddr (rd_ptr_reg[AW-1:0]),
        .rdata (rd_data)
    );

    // Head presentation: bypassed input, stored head, or NOP when empty.
    always_comb begin
        bus.o_valid = ~empty;
        bus.o_pc    = rd_data[2*XLEN-1:XLEN];
        bus.o_instr = rd_data[XLEN-1:0];
        if (bypass) begin
            bus.o_valid = 1'b1;
            bus.o_pc    = bus.i_pc;
            bus.o_instr = bus.i_instr;
        end else if (empty) begin
            bus.o_pc    = XLEN'(PC_RESET);
            bus.o_instr = XLEN'(NOP);
        end
    end

    // Next pointers: flush empties the queue and wins over push and pop.
    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        if (bus.i_flush) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
        end else begin
            if (push) wr_ptr_next = wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_next = rd_ptr_reg + 1'b1;
        end
    end

    // Pointer registers; reset zeroes them and leaves storage untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: the stimulus process keeps a reference
// occupancy and a queue of expected head entries; a monitor pops and compares
// whenever decode consumes the head.
module tb_fetch_queue;
    import fetch_queue_pkg::*;

    localparam int DEPTH = 4;
    localparam int XLEN  = 32;
`ifdef FETCH_QUEUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fetch_queue_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus ();

    fetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int     n_checks = 0;
    int     n_errors = 0;
    entry_t exp_q[$];
    int     model_count = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // One cycle of stimulus, entered 1 time unit after a rising edge.
    task automatic cycle(input logic v, input logic [31:0] pc, input logic [31:0] instr,
                         input logic rdy, input logic fl, input logic r);
        logic byp, acc, pop;
        bus.i_valid = v;
        bus.i_pc    = pc;
        bus.i_instr = instr;
        bus.i_ready = rdy;
        bus.i_flush = fl;
        rst         = r;
        #1;
        byp = BYP && (model_count == 0) && v && !fl;
        check("count", 64'(bus.o_count), 64'(model_count));
        check("ready", 64'(bus.o_ready), 64'(model_count < DEPTH));
        check("valid", 64'(bus.o_valid), 64'((model_count > 0) || byp));
        if (byp) begin
            check("byp_pc", 64'(bus.o_pc), 64'(pc));
            check("byp_instr", 64'(bus.o_instr), 64'(instr));
        end else if (model_count == 0) begin
            check("empty_pc", 64'(bus.o_pc), 64'(0));
            check("empty_instr", 64'(bus.o_instr), 64'(NOP));
        end
        $display("cyc v=%0d pc=%0h rdy=%0d fl=%0d rst=%0d count=%0d", v, pc, rdy, fl, r, model_count);
        if (fl || r) begin
            exp_q.delete();
            model_count = 0;
        end else begin
            acc = v && (model_count < DEPTH);
            pop = (model_count > 0) && rdy;
            if (acc) exp_q.push_back('{pc: pc, instr: instr});
            model_count = model_count + ((acc && !(byp && rdy)) ? 1 : 0) - (pop ? 1 : 0);
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: every consumed head must be the oldest outstanding entry.
    initial begin
        entry_t e;
        forever begin
            @(negedge clk);
            if (bus.o_valid === 1'b1 && bus.i_ready === 1'b1 &&
                bus.i_flush === 1'b0 && rst === 1'b0) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_head: got pc %0h expected no entry", bus.o_pc);
                end else begin
                    e = exp_q.pop_front();
                    check("head_pc", 64'(bus.o_pc), 64'(e.pc));
                    check("head_instr", 64'(bus.o_instr), 64'(e.instr));
                end
            end
        end
    end

    initial begin
        logic [31:0] pc_ctr;
        bus.i_valid = 1'b0;
        bus.i_pc    = '0;
        bus.i_instr = '0;
        bus.i_ready = 1'b0;
        bus.i_flush = 1'b0;
        rst         = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        cycle(0, 0, 0, 0, 0, 1);
        // Reset state and idle
        cycle(0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0);

        // Fill to DEPTH, fifth push refused, then pop in order
        for (int i = 0; i < 4; i++) cycle(1, 32'(i * 4), $urandom, 0, 0, 0);
        cycle(1, 32'h10, $urandom, 0, 0, 0);
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1, 0, 0);
        cycle(0, 0, 0, 0, 0, 0);

        // Continuous push and pop across the pointer wrap
        for (int i = 0; i < 10; i++) cycle(1, 32'(i * 4), $urandom, 1, 0, 0);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1, 0, 0);

        // Flush with a simultaneous push
        for (int i = 0; i < 3; i++) cycle(1, 32'h20 + 32'(i * 4), $urandom, 0, 0, 0);
        cycle(1, 32'h40, $urandom, 0, 1, 0);
        cycle(0, 0, 0, 1, 0, 0);
        cycle(0, 0, 0, 1, 0, 0);

        // Full queue with push and pop together: pop only
        for (int i = 0; i < 4; i++) cycle(1, 32'h80 + 32'(i * 4), $urandom, 0, 0, 0);
        cycle(1, 32'h90, $urandom, 1, 0, 0);
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1, 0, 0);

        // Bypass of an empty queue (same-cycle consume)
        if (BYP) begin
            cycle(1, 32'h100, $urandom, 1, 0, 0);
            cycle(0, 0, 0, 1, 0, 0);
        end

        // Randomized traffic with occasional flush and reset
        pc_ctr = 32'h1000;
        for (int i = 0; i < 600; i++) begin
            cycle($urandom_range(0, 3) != 0, pc_ctr, $urandom, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 19) == 0, $urandom_range(0, 49) == 0);
            pc_ctr = pc_ctr + 32'd4;
        end

        // Drain and confirm nothing accepted was lost
        for (int i = 0; i < DEPTH + 2; i++) cycle(0, 0, 0, 1, 0, 0);
        check("drained", 64'(exp_q.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Decoupling instruction queue between the fetch stage (IF) and the decode stage (ID).
- Buffers fetched {pc, instr} pairs so that imem wait states and decode back-pressure do not stall each other cycle by cycle.
- Flushed on any PC redirect (branch taken, jal, jalr) so wrong-path instructions never reach decode.
- Presents a NOP to decode whenever it holds no valid entry.

Parameters:
- DEPTH, 4, number of entries; power of two, at least 2.
- XLEN, 32, width of pc and instruction fields.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- i_valid  input  1  IF presents a fetched instruction this cycle.
- i_pc  input  XLEN  pc of the presented instruction.
- i_instr  input  XLEN  presented instruction word.
- o_ready  output  1  queue can accept a push this cycle.
- o_valid  output  1  head entry valid toward ID.
- o_pc  output  XLEN  head pc.
- o_instr  output  XLEN  head instruction; NOP (32'h00000013) when o_valid=0.
- i_ready  input  1  ID consumes the head this cycle.
- i_flush  input  1  redirect: discard all contents.
- o_count  output  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Storage: circular buffer of DEPTH entries {pc, instr}.
- Pointers: wr_ptr and rd_ptr, each $clog2(DEPTH)+1 bits; the MSB is the wrap bit.
  - empty = pointers equal.
  - full = index bits equal and wrap bits differ.
  - o_count = wr_ptr - rd_ptr (modulo arithmetic).
- Push = i_valid & o_ready & ~i_flush. Writes the entry at wr_ptr; wr_ptr increments.
- Pop = o_valid & i_ready & ~i_flush. rd_ptr increments.
- o_ready = ~full, registered-state only. It does not depend on i_ready, so there is no combinational path from ID to IF.
  - Consequence: when full, a push is refused even if a pop occurs in the same cycle.
- Simultaneous push and pop when not full or empty: both take effect; occupancy unchanged.
- Latency: a pushed entry becomes visible at the head the cycle after the push (1-cycle latency, no bypass in the base configuration).
- Head outputs:
  - o_valid = ~empty.
  - o_pc and o_instr are driven from the rd_ptr entry.
  - When empty: o_pc = 0 and o_instr = NOP.
- Flush: the next state is empty, with wr_ptr = rd_ptr = 0.
  - A push in the same cycle is dropped.
  - A pop in the same cycle is ignored.
  - Flush has priority over everything except rst.
- Reset: pointers = 0. After reset, o_valid=0, o_ready=1, o_count=0, o_pc=0, o_instr=NOP. Entry storage is not cleared.
- Reset asserted mid-operation: behaves identically to flush plus pointer zeroing; contents are lost.
- Wrap-around: pointers roll over modulo 2*DEPTH. Ordering is preserved across the wrap.
- The queue never reorders entries, never drops an accepted entry except on flush or rst, and never duplicates one.

Optional Feature:
- Macro: FETCH_QUEUE_BYPASS_EN.
- Defined:
  - When empty, i_valid=1 and no flush, the input is driven combinationally onto o_valid, o_pc and o_instr (zero latency).
  - If i_ready=1 in that same cycle, the instruction is consumed directly and not written.
  - If i_ready=0, it is written normally.
  - o_ready is unchanged.
- Undefined: strict 1-cycle latency as described in Behaviour; no combinational path from i_* to o_*.

Decomposition:
- The shared parameters include file holds:
  - the NOP encoding;
  - PC_RESET;
  - the XLEN default.
- One natural sub-module: fetch_queue_ram, a DEPTH x (2*XLEN) register array with one synchronous write port and one asynchronous read port.
- The pointer, full/empty and flush logic stay in fetch_queue.

Test Plan:
- Reset, then idle → o_valid=0, o_ready=1, o_instr=32'h00000013, o_count=0.
- Push pc 0x0/0x4/0x8/0xC with i_ready=0 → o_count=4, o_ready=0; a 5th push of pc 0x10 is refused. Then i_ready=1 pops in order 0x0, 0x4, 0x8, 0xC, one per cycle.
- Continuous push and pop for 10 entries with DEPTH=4 → pointers wrap; output pc sequence is 0x0..0x24 in order with no gaps.
- Queue holding 3 entries, assert i_flush with i_valid=1 (pc 0x40) → next cycle o_valid=0 and o_count=0; pc 0x40 never appears.
- Full queue with i_valid=1 and i_ready=1 → pop occurs, push refused; o_count drops 4→3.
- With FETCH_QUEUE_BYPASS_EN: empty queue, i_valid=1, i_pc=0x100, i_ready=1 → same-cycle o_valid=1, o_pc=0x100; o_count stays 0.
